// File: rtl/ifft_pkg.sv
// Shared constants, twiddle table and state encoding for the 8-point (I)FFT blocks.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package ifft_pkg;

    localparam int DW   = 32;   // sample component width, signed Q24.8
    localparam int FRAC = 8;    // fractional bits, twiddle scale 2^FRAC
    localparam int C45  = 181;  // round(cos(pi/4) * 2^FRAC)

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        CALC  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Inverse twiddles e^{+j*pi*t/4}, real part.
    function automatic logic signed [DW-1:0] tw_re(input logic [1:0] t);
        case (t)
            2'd0:    return DW'(256);
            2'd1:    return DW'(C45);
            2'd2:    return DW'(0);
            default: return -DW'(C45);
        endcase
    endfunction

    // Inverse twiddles e^{+j*pi*t/4}, imaginary part.
    function automatic logic signed [DW-1:0] tw_im(input logic [1:0] t);
        case (t)
            2'd0:    return DW'(0);
            2'd1:    return DW'(C45);
            2'd2:    return DW'(256);
            default: return DW'(C45);
        endcase
    endfunction

    function automatic logic [2:0] bitrev3(input logic [2:0] k);
        return {k[0], k[1], k[2]};
    endfunction

endpackage

// File: rtl/cbfly_q8.sv
// Combinational radix-2 complex butterfly, Q.8 twiddle, halves both outputs.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; caller decides when results are captured.
module cbfly_q8
    import ifft_pkg::*;
(
    input  logic signed [DW-1:0] top_re,
    input  logic signed [DW-1:0] top_im,
    input  logic signed [DW-1:0] bot_re,
    input  logic signed [DW-1:0] bot_im,
    input  logic        [1:0]    tidx,
    output logic signed [DW-1:0] sum_re,
    output logic signed [DW-1:0] sum_im,
    output logic signed [DW-1:0] dif_re,
    output logic signed [DW-1:0] dif_im
);
    localparam int WW = 2 * DW;
    localparam int SW = DW + 1;

    logic signed [WW-1:0] wr, wi, br, bi, pr_full, pi_full;
    logic signed [SW-1:0] ts_re, ts_im, td_re, td_im;

    // Twiddle multiply at full width, rescale by 2^FRAC, then halve sum/difference.
    always_comb begin
        wr      = WW'(tw_re(tidx));
        wi      = WW'(tw_im(tidx));
        br      = WW'(bot_re);
        bi      = WW'(bot_im);
        pr_full = (br * wr - bi * wi) >>> FRAC;
        pi_full = (br * wi + bi * wr) >>> FRAC;
        ts_re   = SW'(top_re) + SW'(pr_full);
        ts_im   = SW'(top_im) + SW'(pi_full);
        td_re   = SW'(top_re) - SW'(pr_full);
        td_im   = SW'(top_im) - SW'(pi_full);
        sum_re  = DW'(ts_re >>> 1);
        sum_im  = DW'(ts_im >>> 1);
        dif_re  = DW'(td_re >>> 1);
        dif_im  = DW'(td_im >>> 1);
    end

endmodule

// File: rtl/ifft8_seq.sv
// Iterative 8-point radix-2 DIT inverse FFT with one shared butterfly, Q24.8 in and out.
// Latency: first out_valid 13 edges after the 8th input accept (12 butterflies + 1 output load).
// Backpressure: input refused outside LOAD; output held stable while out_ready is low.
module ifft8_seq
    import ifft_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] in_real,
    input  logic signed [DW-1:0] in_imag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [DW-1:0] out_real,
    output logic signed [DW-1:0] out_imag,
    output logic        [2:0]    out_index,
    output logic                 out_last,
    output logic                 busy
);
    state_t state, state_nx;

    logic [2:0] lcnt;   // load counter k
    logic [1:0] stg;    // stage s
    logic [1:0] bfy;    // butterfly b within stage
    logic [2:0] n;      // output index

    logic signed [DW-1:0] mem_re [8];
    logic signed [DW-1:0] mem_im [8];

    logic [2:0] h, pos, top_a, bot_a, tfull;
    logic [1:0] tidx;
    logic signed [DW-1:0] sum_re, sum_im, dif_re, dif_im;

    // Butterfly addressing: pos = b mod h, top = (b/h)*2h + pos, bot = top + h, t = pos*(4/h).
    always_comb begin
        h     = 3'd1 << stg;
        pos   = {1'b0, bfy} & (h - 3'd1);
        top_a = (({1'b0, bfy} >> stg) << ({1'b0, stg} + 3'd1)) | pos;
        bot_a = top_a + h;
        tfull = pos << (2'd2 - stg);
        tidx  = tfull[1:0];
    end

    cbfly_q8 u_bfly (
        .top_re (mem_re[top_a]),
        .top_im (mem_im[top_a]),
        .bot_re (mem_re[bot_a]),
        .bot_im (mem_im[bot_a]),
        .tidx   (tidx),
        .sum_re (sum_re),
        .sum_im (sum_im),
        .dif_re (dif_re),
        .dif_im (dif_im)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= LOAD;
        else        state <= state_nx;
    end

    // Next-state and status outputs.
    always_comb begin
        state_nx = state;
        in_ready = 1'b0;
        busy     = 1'b1;
        case (state)
            LOAD: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid && lcnt == 3'd7) state_nx = CALC;
            end
            CALC: begin
                if (stg == 2'd2 && bfy == 2'd3) state_nx = DRAIN;
            end
            DRAIN: begin
                if (out_valid && out_ready && n == 3'd7) state_nx = LOAD;
            end
            default: state_nx = LOAD;
        endcase
    end

    // Datapath: bit-reversed load, in-place butterflies, registered output stream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lcnt      <= '0;
            stg       <= '0;
            bfy       <= '0;
            n         <= '0;
            out_valid <= 1'b0;
            out_real  <= '0;
            out_imag  <= '0;
            for (int i = 0; i < 8; i++) begin
                mem_re[i] <= '0;
                mem_im[i] <= '0;
            end
        end else begin
            case (state)
                LOAD: begin
                    if (in_valid) begin
                        mem_re[bitrev3(lcnt)] <= in_real;
                        mem_im[bitrev3(lcnt)] <= in_imag;
                        lcnt                  <= lcnt + 3'd1;
                    end
                end
                CALC: begin
                    mem_re[top_a] <= sum_re;
                    mem_im[top_a] <= sum_im;
                    mem_re[bot_a] <= dif_re;
                    mem_im[bot_a] <= dif_im;
                    bfy           <= bfy + 2'd1;
                    if (bfy == 2'd3) stg <= (stg == 2'd2) ? 2'd0 : stg + 2'd1;
                end
                DRAIN: begin
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                        out_real  <= mem_re[n];
                        out_imag  <= mem_im[n];
                    end else if (out_ready) begin
                        if (n == 3'd7) begin
                            out_valid <= 1'b0;
                            n         <= '0;
                            out_real  <= '0;
                            out_imag  <= '0;
                        end else begin
                            n        <= n + 3'd1;
                            out_real <= mem_re[n + 3'd1];
                            out_imag <= mem_im[n + 3'd1];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_index = n;
    assign out_last  = out_valid & (n == 3'd7);

endmodule

// File: tb/tb_ifft8_seq.sv
module tb_ifft8_seq;
    import ifft_pkg::*;

    typedef int vec_t [8];

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] in_real;
    logic signed [DW-1:0] in_imag;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [DW-1:0] out_real;
    logic signed [DW-1:0] out_imag;
    logic        [2:0]    out_index;
    logic                 out_last;
    logic                 busy;

    int checks = 0;
    int errors = 0;

    vec_t zeros    = '{0, 0, 0, 0, 0, 0, 0, 0};
    vec_t dc_in    = '{2048, 0, 0, 0, 0, 0, 0, 0};
    vec_t tone_in  = '{0, 2048, 0, 0, 0, 0, 0, 0};
    vec_t all256   = '{256, 256, 256, 256, 256, 256, 256, 256};
    vec_t tone_re  = '{256, 181, 0, -181, -256, -181, 0, 181};
    vec_t tone_im  = '{0, 181, 256, 181, 0, -181, -256, -181};
    vec_t rt_in_re = '{7168, -3496, -2048, -1448, -1024, -600, 0, 1448};
    vec_t rt_in_im = '{7168, 1448, 0, -600, -1024, -1448, -2048, -3496};
    vec_t ramp     = '{0, 256, 512, 768, 1024, 1280, 1536, 1792};

    ifft8_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_real   (in_real),
        .in_imag   (in_imag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_real  (out_real),
        .out_imag  (out_imag),
        .out_index (out_index),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint got, input longint exp, input longint tol);
        longint d;
        checks++;
        d = got - exp;
        if (d < 0) d = -d;
        if (d > tol) begin
            errors++;
            $display("FAIL %s got %0d expected %0d (tol %0d)", tag, got, exp, tol);
        end
    endtask

    task automatic send_frame(input vec_t re, input vec_t im, input bit hold_valid);
        int w;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_real  = DW'(re[k]);
            in_imag  = DW'(im[k]);
            w = 0;
            while (!in_ready && w < 100) begin
                @(negedge clk);
                w++;
            end
            if (w >= 100) check("in_ready timeout", 0, 1, 0);
            @(posedge clk);
            #1;
        end
        if (!hold_valid) in_valid = 1'b0;
    endtask

    task automatic recv_frame(input vec_t ere, input vec_t eim, input int tol, input bit bp, input string name);
        int  n;
        int  c;
        int  guard;
        bit  rdy;
        n = 0;
        c = 0;
        guard = 0;
        while (n < 8 && guard < 300) begin
            @(negedge clk);
            guard++;
            if (out_valid) begin
                check({name, " idx"},  out_index, n, 0);
                check({name, " re"},   $signed(out_real), ere[n], tol);
                check({name, " im"},   $signed(out_imag), eim[n], tol);
                check({name, " last"}, out_last, (n == 7) ? 1 : 0, 0);
                check({name, " in_ready low"}, in_ready, 0, 0);
                rdy = bp ? ((c % 4 == 0) || (c % 4 == 3)) : 1'b1;
                c++;
                out_ready = rdy;
                @(posedge clk);
                #1;
                if (rdy) n++;
                else check({name, " valid held"}, out_valid, 1, 0);
            end
        end
        if (n < 8) check({name, " drain timeout"}, n, 8, 0);
    endtask

    initial begin
        int cnt;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_real   = '0;
        in_imag   = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst in_ready",  in_ready, 1, 0);
        check("rst out_valid", out_valid, 0, 0);
        check("rst busy",      busy, 0, 0);
        check("rst out_real",  $signed(out_real), 0, 0);
        check("rst out_imag",  $signed(out_imag), 0, 0);
        check("rst out_index", out_index, 0, 0);
        check("rst out_last",  out_last, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // DC impulse
        send_frame(dc_in, zeros, 1'b0);
        recv_frame(all256, zeros, 0, 1'b0, "dc");
        check("dc post in_ready",  in_ready, 1, 0);
        check("dc post out_valid", out_valid, 0, 0);
        check("dc post busy",      busy, 0, 0);

        // Single tone, in_valid held high throughout, latency measured
        send_frame(tone_in, zeros, 1'b1);
        check("lat in_ready after 8th", in_ready, 0, 0);
        check("lat busy", busy, 1, 0);
        cnt = 0;
        while (!out_valid && cnt < 40) begin
            @(posedge clk);
            #1;
            cnt++;
            if (!out_valid) check("lat in_ready calc", in_ready, 0, 0);
        end
        check("latency edges", cnt, 13, 0);
        recv_frame(tone_re, tone_im, 0, 1'b0, "tone");
        in_valid = 1'b0;
        check("tone post in_ready",  in_ready, 1, 0);
        check("tone post out_valid", out_valid, 0, 0);

        // Backpressure 1,0,0,1 pattern
        send_frame(tone_in, zeros, 1'b0);
        recv_frame(tone_re, tone_im, 0, 1'b1, "bp");

        // Round trip of fft8 output for x[n] = (n*256, n*256)
        send_frame(rt_in_re, rt_in_im, 1'b0);
        recv_frame(ramp, ramp, 2, 1'b0, "rt");

        // Reset during the 6th butterfly
        send_frame(tone_in, zeros, 1'b0);
        check("mid busy", busy, 1, 0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid rst in_ready",  in_ready, 1, 0);
        check("mid rst busy",      busy, 0, 0);
        check("mid rst out_valid", out_valid, 0, 0);
        check("mid rst out_index", out_index, 0, 0);
        check("mid rst out_real",  $signed(out_real), 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        send_frame(dc_in, zeros, 1'b0);
        recv_frame(all256, zeros, 0, 1'b0, "post rst dc");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
